// File: rtl/matmul_op_sequencer_pkg.sv
// Shared definitions for the PIM matmul sequencer: default sizing, sequencer
// state encoding and the command/operation record layouts.
package pim_pkg;

    localparam int DEF_LEN             = 32;
    localparam int DEF_MEM_ELEMENTS    = 1024;
    localparam int DEF_MAX_MATRIX_SIZE = 16;
    localparam int MAX_LOG2_SIZE       = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [DEF_LEN-1:0] src1;
        logic [DEF_LEN-1:0] src2;
        logic [DEF_LEN-1:0] dst;
        logic [2:0]         size;
    } matmul_cmd_t;

    typedef struct packed {
        logic [DEF_LEN-1:0] a;
        logic [DEF_LEN-1:0] b;
        logic [DEF_LEN-1:0] c;
        logic               first;
        logic               last;
    } matmul_op_t;

endpackage

// File: rtl/matmul_op_sequencer_if.sv
// Command-in / operation-out bundle of the matmul sequencer. master is the
// upstream+datapath side, slave is the sequencer itself.
interface matmul_op_sequencer_if #(
    parameter int LEN = 32
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [LEN-1:0] src1_addr;
    logic [LEN-1:0] src2_addr;
    logic [LEN-1:0] dst_addr;
    logic [2:0]     matrix_size;

    logic           op_valid;
    logic           op_ready;
    logic [LEN-1:0] op_a_addr;
    logic [LEN-1:0] op_b_addr;
    logic [LEN-1:0] op_c_addr;
    logic           op_first;
    logic           op_last;

    logic           busy;
    logic           done;
    logic           err;

    modport master (
        output cmd_valid, src1_addr, src2_addr, dst_addr, matrix_size, op_ready,
        input  cmd_ready, op_valid, op_a_addr, op_b_addr, op_c_addr,
               op_first, op_last, busy, done, err
    );

    modport slave (
        input  cmd_valid, src1_addr, src2_addr, dst_addr, matrix_size, op_ready,
        output cmd_ready, op_valid, op_a_addr, op_b_addr, op_c_addr,
               op_first, op_last, busy, done, err
    );
endinterface

// File: rtl/matmul_op_sequencer_loop_ctr.sv
// i/j/k loop nest for an n x n x n matmul (n = 2**log2_size); k is innermost.
// Each level rolls over to zero at n-1 and carries into the next level.
module matmul_loop_ctr
    import pim_pkg::*;
#(
    parameter int CW = MAX_LOG2_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] log2_size,
    output logic       k_first,
    output logic       k_last,
    output logic       j_last,
    output logic       final_op
);

    logic [CW-1:0] top_val;
    logic [2:0]    carry;
    logic [2:0]    at_max;
    logic [CW-1:0] k_val;

    assign top_val  = CW'((32'd1 << log2_size) - 32'd1);
    assign carry[0] = en;

    // Level 0 is k, level 1 is j, level 2 is i.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            assign at_max[gi] = (cnt_reg == top_val);

            if (gi < 2) begin : g_carry
                assign carry[gi+1] = carry[gi] & at_max[gi];
            end

            always_comb begin
                cnt_next = cnt_reg;
                if (clr) begin
                    cnt_next = '0;
                end else if (carry[gi]) begin
                    cnt_next = at_max[gi] ? '0 : cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    assign k_val    = g_cnt[0].cnt_reg;
    assign k_first  = (k_val == '0);
    assign k_last   = at_max[0];
    assign j_last   = at_max[1];
    assign final_op = &at_max;

endmodule

// File: rtl/matmul_op_sequencer.sv
// Accepts one matmul command, range/size checks it, then streams n^3 MAC
// operations (i outer, j middle, k inner) with pointer arithmetic only.
module matmul_op_sequencer
    import pim_pkg::*;
#(
    parameter int LEN             = DEF_LEN,
    parameter int MEM_ELEMENTS    = DEF_MEM_ELEMENTS,
    parameter int MAX_MATRIX_SIZE = DEF_MAX_MATRIX_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    matmul_op_sequencer_if.slave bus
);

    localparam int MAX_LOG2 = $clog2(MAX_MATRIX_SIZE);
    localparam int CW       = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
    localparam logic [LEN:0] MEM_LIMIT = (LEN+1)'(MEM_ELEMENTS);

    seq_state_t     state_reg, state_next;
    logic [LEN-1:0] op_a_reg, op_a_next;
    logic [LEN-1:0] op_b_reg, op_b_next;
    logic [LEN-1:0] op_c_reg, op_c_next;
    logic [LEN-1:0] row_a_reg, row_a_next;
    logic [LEN-1:0] col_b_reg, col_b_next;
    logic [LEN-1:0] src2_reg, src2_next;
    logic [LEN-1:0] n_reg, n_next;
    logic [2:0]     size_reg, size_next;
    logic           done_reg, done_next;
    logic           err_reg, err_next;

    logic           ctr_clr, ctr_en;
    logic           k_first, k_last, j_last, final_op;

    logic [LEN:0]   span;
    logic [LEN:0]   end_a, end_b, end_c;
    logic           size_bad, range_bad;

    // Top-element addresses carry one extra bit so a wrapped sum is caught.
    always_comb begin
        span      = (LEN+1)'(1) << {bus.matrix_size, 1'b0};
        end_a     = {1'b0, bus.src1_addr} + span - (LEN+1)'(1);
        end_b     = {1'b0, bus.src2_addr} + span - (LEN+1)'(1);
        end_c     = {1'b0, bus.dst_addr}  + span - (LEN+1)'(1);
        size_bad  = (bus.matrix_size > 3'(MAX_LOG2));
        range_bad = (end_a >= MEM_LIMIT) || (end_b >= MEM_LIMIT) || (end_c >= MEM_LIMIT);
    end

    matmul_loop_ctr #(
        .CW(CW)
    ) u_loop_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr       (ctr_clr),
        .en        (ctr_en),
        .log2_size (size_reg),
        .k_first   (k_first),
        .k_last    (k_last),
        .j_last    (j_last),
        .final_op  (final_op)
    );

    always_comb begin
        state_next = state_reg;
        op_a_next  = op_a_reg;
        op_b_next  = op_b_reg;
        op_c_next  = op_c_reg;
        row_a_next = row_a_reg;
        col_b_next = col_b_reg;
        src2_next  = src2_reg;
        n_next     = n_reg;
        size_next  = size_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        ctr_clr    = 1'b0;
        ctr_en     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (size_bad || range_bad) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = ISSUE;
                        ctr_clr    = 1'b1;
                        op_a_next  = bus.src1_addr;
                        op_b_next  = bus.src2_addr;
                        op_c_next  = bus.dst_addr;
                        row_a_next = bus.src1_addr;
                        col_b_next = bus.src2_addr;
                        src2_next  = bus.src2_addr;
                        n_next     = LEN'(1) << bus.matrix_size;
                        size_next  = bus.matrix_size;
                    end
                end
            end
            ISSUE: begin
                if (bus.op_ready) begin
                    ctr_en = 1'b1;
                    if (final_op) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if (!k_last) begin
                        op_a_next = op_a_reg + 1'b1;
                        op_b_next = op_b_reg + n_reg;
                    end else if (!j_last) begin
                        // Next column of C: restart the A row, step to next B column.
                        op_a_next  = row_a_reg;
                        op_b_next  = col_b_reg + 1'b1;
                        col_b_next = col_b_reg + 1'b1;
                        op_c_next  = op_c_reg + 1'b1;
                    end else begin
                        // Next row of C: A row end + 1 is the next row start.
                        op_a_next  = op_a_reg + 1'b1;
                        row_a_next = op_a_reg + 1'b1;
                        op_b_next  = src2_reg;
                        col_b_next = src2_reg;
                        op_c_next  = op_c_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            op_c_reg  <= '0;
            row_a_reg <= '0;
            col_b_reg <= '0;
            src2_reg  <= '0;
            n_reg     <= '0;
            size_reg  <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_a_reg  <= op_a_next;
            op_b_reg  <= op_b_next;
            op_c_reg  <= op_c_next;
            row_a_reg <= row_a_next;
            col_b_reg <= col_b_next;
            src2_reg  <= src2_next;
            n_reg     <= n_next;
            size_reg  <= size_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.busy      = (state_reg == ISSUE);
    assign bus.op_valid  = (state_reg == ISSUE);
    assign bus.op_a_addr = op_a_reg;
    assign bus.op_b_addr = op_b_reg;
    assign bus.op_c_addr = op_c_reg;
    assign bus.op_first  = (state_reg == ISSUE) && k_first;
    assign bus.op_last   = (state_reg == ISSUE) && k_last;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;

endmodule
